// File: rtl/dbg_bridge_pkg.sv
// dbg_bridge_pkg
//   Shared types and constants for the debug command bridge (dbg_cmd_bridge
//   and its response serializer dbg_bridge_tx).
//   Frame layout on the RX byte stream (little-endian fields):
//     CMD, A0..A3, D0..D3                     -> FRAME_LEN bytes
//   Response on the TX byte stream:
//     CMD echo (or RESP_TIMEOUT), R0..R3       -> RESP_LEN bytes
package dbg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        ISSUE,
        WAIT_RDY,
        TX
    } state_t;

    localparam int FRAME_LEN = 9;
    localparam int RESP_LEN  = 5;

    // Bytes per address/data field: the frame minus the command byte, split in two.
    localparam int FIELD_BYTES = (FRAME_LEN - 1) / 2;

    localparam logic [7:0] CMD_NOP      = 8'h00;
    localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

endpackage

// File: rtl/dbg_bridge_tx.sv
// dbg_bridge_tx
//   Response serializer. A load strobe captures a RESP_LEN-byte word; the
//   bytes are then presented lowest byte first with valid/ready handshaking.
//   Valid stays high across byte boundaries and drops after the last accept.
// Ports
//   clk         in   system clock
//   rst_i       in   synchronous reset, active-high
//   load_i      in   capture word_i and start sending
//   word_i      in   response word, byte 0 in bits [7:0]
//   tx_data_o   out  current response byte
//   tx_valid_o  out  tx_data_o valid
//   tx_ready_i  in   sink accepts tx_data_o this cycle
//   done_o      out  pulses on the cycle the last byte is accepted
module dbg_bridge_tx
    import dbg_bridge_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [8*RESP_LEN-1:0]   word_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    done_o
);

    logic [8*RESP_LEN-1:0] word_q, word_d;
    logic [2:0]            idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  accept;
    logic                  last;

    assign accept = valid_q && tx_ready_i;
    assign last   = (idx_q == 3'(RESP_LEN - 1));

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = word_i;
            idx_d   = 3'd0;
            valid_d = 1'b1;
        end else if (accept) begin
            if (last) begin
                idx_d   = 3'd0;
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            word_q  <= '0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = word_q[{idx_q, 3'b000} +: 8];
    assign tx_valid_o = valid_q;
    assign done_o     = accept && last;

endmodule

// File: rtl/dbg_cmd_bridge.sv
// dbg_cmd_bridge
//   Byte-stream front end for dbg_module. Assembles 9-byte command frames
//   from the UART RX stream, issues cmd/addr/data to dbg_module, waits for
//   its ready, and returns a 5-byte response (command echo + 32-bit read
//   data) on the UART TX stream.
//   Optional feature macro: DBG_TIMEOUT_EN -- abort WAIT_RDY after
//   TIMEOUT_CYCLES cycles and answer with RESP_TIMEOUT followed by zeros.
// Ports
//   clk          in   system clock
//   rst_i        in   synchronous reset, active-high
//   rx_data_i    in   received byte
//   rx_valid_i   in   1-cycle strobe for rx_data_i (no backpressure)
//   tx_data_o    out  response byte
//   tx_valid_o   out  response byte valid, held until tx_ready_i
//   tx_ready_i   in   TX accepts tx_data_o
//   dbg_cmd_o    out  command to dbg_module (00 = NOP)
//   dbg_addr_o   out  address to dbg_module
//   dbg_data_o   out  write data to dbg_module
//   dbg_data_i   in   read data from dbg_module
//   dbg_ready_i  in   dbg_module done/idle
//   busy_o       out  frame in progress
//   overrun_o    out  sticky: byte dropped while not receiving
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a non-NOP command byte
// RX_ADDR  | collecting address bytes A0..A3
// RX_DATA  | collecting data bytes D0..D3
// ISSUE    | first cycle of the command on dbg_*; dbg_ready_i ignored
// WAIT_RDY | command held until dbg_ready_i (or timeout when enabled)
// TX       | response bytes being handed to the TX stream
module dbg_cmd_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i,
    output logic        busy_o,
    output logic        overrun_o
);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [7:0]            dbg_cmd_q, dbg_cmd_d;
    logic                  overrun_q, overrun_d;
    logic                  tx_load;
    logic [8*RESP_LEN-1:0] tx_word;
    logic                  tx_done;
    logic                  field_last;

`ifdef DBG_TIMEOUT_EN
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
`else
    // Parameter kept for a uniform interface; it has no effect in this build.
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    assign field_last = (cnt_q == 2'(FIELD_BYTES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        dbg_cmd_d = dbg_cmd_q;
        overrun_d = overrun_q;
        tx_load   = 1'b0;
        tx_word   = '0;
`ifdef DBG_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                if (rx_valid_i && (rx_data_i != CMD_NOP)) begin
                    cmd_d   = rx_data_i;
                    cnt_d   = 2'd0;
                    state_d = RX_ADDR;
                end
            end
            RX_ADDR: begin
                if (rx_valid_i) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (field_last) begin
                        cnt_d   = 2'd0;
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_valid_i) begin
                    data_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (field_last) begin
                        cnt_d     = 2'd0;
                        // Registered here so the command is on the bus during ISSUE.
                        dbg_cmd_d = cmd_q;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
`ifdef DBG_TIMEOUT_EN
                tmo_d = TMO_LOAD;
`endif
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                // Ready on the expiry cycle takes priority over the timeout.
                if (dbg_ready_i) begin
                    tx_load   = 1'b1;
                    tx_word   = {dbg_data_i, cmd_q};
                    dbg_cmd_d = CMD_NOP;
                    state_d   = TX;
                end
`ifdef DBG_TIMEOUT_EN
                else if (tmo_q == 32'd0) begin
                    tx_load   = 1'b1;
                    tx_word   = {32'd0, RESP_TIMEOUT};
                    dbg_cmd_d = CMD_NOP;
                    state_d   = TX;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
`endif
            end
            TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No backpressure on RX: bytes arriving outside a frame are lost.
        if (rx_valid_i && ((state_q == ISSUE) || (state_q == WAIT_RDY) || (state_q == TX))) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            cmd_q     <= 8'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            dbg_cmd_q <= 8'd0;
            overrun_q <= 1'b0;
`ifdef DBG_TIMEOUT_EN
            tmo_q     <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dbg_cmd_q <= dbg_cmd_d;
            overrun_q <= overrun_d;
`ifdef DBG_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    dbg_bridge_tx u_tx (
        .clk        (clk),
        .rst_i      (rst_i),
        .load_i     (tx_load),
        .word_i     (tx_word),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .done_o     (tx_done)
    );

    assign dbg_cmd_o  = dbg_cmd_q;
    assign dbg_addr_o = addr_q;
    assign dbg_data_o = data_q;
    assign busy_o     = (state_q != IDLE);
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Bench for dbg_cmd_bridge: directed frames followed by randomized frames,
// checked against a frame-level reference (expected command bus contents,
// the 5-byte response built from the frame rules, and a sticky overrun flag).
module tb_dbg_cmd_bridge;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i = 32'h0;
    logic        dbg_ready_i = 1'b0;
    logic        busy_o;
    logic        overrun_o;

    int   n_cmp = 0;
    int   n_err = 0;
    logic ovr_m = 1'b0;

    always #5 clk = ~clk;

    dbg_cmd_bridge #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .dbg_cmd_o   (dbg_cmd_o),
        .dbg_addr_o  (dbg_addr_o),
        .dbg_data_o  (dbg_data_o),
        .dbg_data_i  (dbg_data_i),
        .dbg_ready_i (dbg_ready_i),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        ovr_m = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx_valid"}, tx_valid_o, 1'b0);
        chk({tag, "_tx_data"}, tx_data_o, 8'h00);
        chk({tag, "_dbg_cmd"}, dbg_cmd_o, 8'h00);
        chk({tag, "_dbg_addr"}, dbg_addr_o, 32'h0);
        chk({tag, "_dbg_data"}, dbg_data_o, 32'h0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_overrun"}, overrun_o, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
    endtask

    // Sends a whole frame with random idle gaps; afterwards the command must be on the bus.
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input int unsigned maxgap);
        logic [7:0] fb [9];
        fb[0] = cmd;
        for (int i = 0; i < 4; i++) begin
            fb[1 + i] = addr[8*i +: 8];
            fb[5 + i] = data[8*i +: 8];
        end
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, maxgap)) tick;
            send_byte(fb[i]);
            if (i == 7) begin
                chk("early_cmd", dbg_cmd_o, 8'h00);
            end
        end
        chk("issue_cmd", dbg_cmd_o, cmd);
        chk("issue_addr", dbg_addr_o, addr);
        chk("issue_data", dbg_data_o, data);
        chk("issue_busy", busy_o, 1'b1);
        chk("issue_tx_valid", tx_valid_o, 1'b0);
    endtask

    // ISSUE cycle then WAIT_RDY for 'delay' cycles, then dbg_ready_i with rdata.
    task automatic wait_phase(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rdata,
                              input int unsigned delay, input logic junk,
                              input logic issue_rdy);
        dbg_ready_i = issue_rdy;
        dbg_data_i  = $urandom;
        rx_valid_i  = junk;
        rx_data_i   = 8'hA5;
        tick;
        rx_valid_i  = 1'b0;
        dbg_ready_i = 1'b0;
        if (junk) ovr_m = 1'b1;
        chk("issue_ready_ignored", dbg_cmd_o, cmd);
        chk("issue_no_tx", tx_valid_o, 1'b0);
        for (int i = 0; i < int'(delay); i++) begin
            if (junk && i == 0) begin
                rx_valid_i = 1'b1;
                rx_data_i  = 8'h5A;
            end
            dbg_data_i = $urandom;
            tick;
            rx_valid_i = 1'b0;
            chk("wait_cmd_hold", dbg_cmd_o, cmd);
            chk("wait_addr_hold", dbg_addr_o, addr);
            chk("wait_data_hold", dbg_data_o, data);
            chk("wait_no_tx", tx_valid_o, 1'b0);
        end
        dbg_ready_i = 1'b1;
        dbg_data_i  = rdata;
        tick;
        dbg_ready_i = 1'b0;
        dbg_data_i  = $urandom;
        chk("resp_valid_latency", tx_valid_o, 1'b1);
        chk("cmd_cleared", dbg_cmd_o, 8'h00);
        chk("overrun_flag", overrun_o, ovr_m);
    endtask

    // mode 0: always ready, 1: random ready, 2: repeating 1-0-0-1 ready pattern.
    task automatic tx_phase(input logic [39:0] resp, input int unsigned mode);
        int         idx = 0;
        int         cyc = 0;
        logic       rdy;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        while (idx < 5 && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            tx_ready_i = rdy;
            chk("tx_valid_held", tx_valid_o, 1'b1);
            if (prev_stall) begin
                chk("tx_data_stable", tx_data_o, prev_data);
            end
            if (rdy) begin
                chk("tx_byte", tx_data_o, resp[8*idx +: 8]);
                idx++;
            end
            prev_stall = !rdy;
            prev_data  = tx_data_o;
            tick;
            cyc++;
        end
        chk("tx_byte_count", idx, 5);
        tx_ready_i = 1'($urandom_range(0, 1));
        chk("tx_done_valid", tx_valid_o, 1'b0);
        chk("tx_done_busy", busy_o, 1'b0);
        tick;
        chk("tx_no_extra", tx_valid_o, 1'b0);
        tx_ready_i = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rdata,
                             input int unsigned maxgap, input int unsigned delay,
                             input logic junk, input logic issue_rdy,
                             input int unsigned mode);
        send_frame(cmd, addr, data, maxgap);
        wait_phase(cmd, addr, data, rdata, delay, junk, issue_rdy);
        tx_phase({rdata, cmd}, mode);
        chk("idle_addr_kept", dbg_addr_o, addr);
        chk("idle_data_kept", dbg_data_o, data);
        chk("idle_cmd_zero", dbg_cmd_o, 8'h00);
        chk("idle_overrun", overrun_o, ovr_m);
    endtask

    initial begin
        logic [7:0] c;
        int         n;

        // Reset state
        tick;
        tick;
        rst_i = 1'b0;
        chk_idle("reset");

        // Basic frame, ready a few cycles after ISSUE
        run_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1234_5678, 0, 2, 1'b0, 1'b0, 0);

        // NOP in IDLE is discarded
        send_byte(8'h00);
        chk("nop_busy", busy_o, 1'b0);
        chk("nop_cmd", dbg_cmd_o, 8'h00);
        tick;
        chk("nop_no_tx", tx_valid_o, 1'b0);
        run_frame(8'h02, 32'h0000_0004, 32'h0, $urandom, 1, 1, 1'b0, 1'b0, 0);

        // TX backpressure pattern
        run_frame(8'h33, $urandom, $urandom, 32'hCAFE_F00D, 0, 0, 1'b0, 1'b1, 2);

        // Bytes dropped while waiting: sticky overrun, following frame still fine
        run_frame(8'h44, $urandom, $urandom, $urandom, 0, 3, 1'b1, 1'b0, 1);
        run_frame(8'h45, 32'h8000_0001, 32'h0102_0304, 32'hA0B0_C0D0, 2, 1, 1'b0, 1'b0, 0);
        chk("overrun_sticky", overrun_o, 1'b1);

        // Reset after 5 frame bytes
        send_byte(8'h07);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        chk("midframe_busy", busy_o, 1'b1);
        pulse_reset;
        chk_idle("midframe_reset");
        run_frame(8'h08, 32'h0000_0020, 32'h5555_AAAA, 32'h0F0F_0F0F, 0, 1, 1'b0, 1'b0, 0);

        // Reset while a response is stalled in TX
        send_frame(8'h09, $urandom, $urandom, 0);
        wait_phase(8'h09, dbg_addr_o, dbg_data_o, $urandom, 0, 1'b0, 1'b0);
        tx_ready_i = 1'b0;
        tick;
        chk("midtx_valid", tx_valid_o, 1'b1);
        pulse_reset;
        chk_idle("midtx_reset");

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            c = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                send_byte(8'h00);
                chk("rnd_nop_busy", busy_o, 1'b0);
            end
            run_frame(c, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 6), ($urandom_range(0, 9) == 0),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

`ifdef DBG_TIMEOUT_EN
        // No ready: abort after 16 WAIT_RDY cycles with a timeout response
        send_frame(8'h5C, $urandom, $urandom, 0);
        dbg_ready_i = 1'b0;
        tick;
        n = 0;
        while (dbg_cmd_o == 8'h5C && n < 100) begin
            tick;
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_tx_valid", tx_valid_o, 1'b1);
        tx_phase({32'h0, 8'hEE}, 1);

        // Ready on the expiry cycle gives the normal response
        run_frame(8'h5D, $urandom, $urandom, 32'h7654_3210, 0, 15, 1'b0, 1'b0, 0);
`else
        n = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
